// File: rtl/ctrl_pkg.sv
// Shared control encodings for the multi-cycle RV32I core: states, opcodes, mux and ALU codes.
// The immediate extender decodes immsrc with the same IMM_* constants.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECUTER,
    S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_LUI, S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic       pcupdate;
    logic       branch;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore output table: every field not set for a state stays 0.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irwrite = 1'b1;  c.alusrca = SRCA_PC;  c.alusrcb = SRCB_FOUR;
        c.resultsrc = RES_ALURESULT;  c.pcupdate = 1'b1;
      end
      S_DECODE:   begin c.alusrca = SRCA_OLDPC; c.alusrcb = SRCB_IMM; end
      S_MEMADR:   begin c.alusrca = SRCA_RS1;   c.alusrcb = SRCB_IMM; end
      S_MEMREAD:  c.adrsrc = 1'b1;
      S_MEMWB:    begin c.resultsrc = RES_DATA; c.regwrite = 1'b1; end
      S_MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
      S_EXECUTER: begin c.alusrca = SRCA_RS1; c.alusrcb = SRCB_RS2; c.aluop = ALUOP_FUNC; end
      S_EXECUTEI: begin c.alusrca = SRCA_RS1; c.alusrcb = SRCB_IMM; c.aluop = ALUOP_FUNC; end
      S_ALUWB:    c.regwrite = 1'b1;
      S_BEQ: begin
        c.alusrca = SRCA_RS1;  c.alusrcb = SRCB_RS2;  c.aluop = ALUOP_SUB;  c.branch = 1'b1;
      end
      S_JAL:      begin c.alusrca = SRCA_OLDPC; c.alusrcb = SRCB_FOUR; c.pcupdate = 1'b1; end
      S_LUI:      begin c.resultsrc = RES_IMMEXT; c.regwrite = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] imm_decode(logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Turns the FSM's coarse aluop into the ALU's alucontrol using funct3/funct7b5/op[5].
// Purely combinational; sub only for R-type (op[5]=1) with funct7b5 set.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          3'b000:  alucontrol = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM with registered Moore outputs; write enables are gated low during reset.
// Optional macro CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap into a sticky ILLEGAL state instead of acting as nops.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [2:0] immsrc,
  output logic       illegal
);

  if (STATE_W < $bits(state_t)) begin : g_state_w_chk
    $error("STATE_W too small to hold all controller states");
  end

  state_t state_q, state_d;
  ctrl_t  ctrl_q;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECUTER;
          OP_I:              state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:           state_d = S_ILLEGAL;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:               state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:              state_d = S_MEMWB;
      S_EXECUTER, S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:                  state_d = S_ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_ILLEGAL:              state_d = S_ILLEGAL;
`endif
      default:                state_d = S_FETCH;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ctrl_q    <= state_ctrl(S_FETCH);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= state_ctrl(state_d);
      illegal_q <= illegal_q | (state_d == S_ILLEGAL);
    end
  end

  assign illegal = illegal_q & ~reset;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
    end
  end

  assign illegal = 1'b0;
`endif

  assign pcwrite   = ~reset & (ctrl_q.pcupdate | (ctrl_q.branch & zero));
  assign memwrite  = ~reset & ctrl_q.memwrite;
  assign irwrite   = ~reset & ctrl_q.irwrite;
  assign regwrite  = ~reset & ctrl_q.regwrite;
  assign adrsrc    = ctrl_q.adrsrc;
  assign resultsrc = ctrl_q.resultsrc;
  assign alusrca   = ctrl_q.alusrca;
  assign alusrcb   = ctrl_q.alusrcb;
  assign immsrc    = imm_decode(op);

  alu_decoder u_alu_decoder (
    .aluop      (ctrl_q.aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instructions, randomized instruction stream, reset and illegal-op cases.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb;
  logic [2:0] alucontrol, immsrc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite), .irwrite(irwrite),
    .regwrite(regwrite), .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .alucontrol(alucontrol), .immsrc(immsrc), .illegal(illegal)
  );

  typedef enum {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_LUI, K_OTHER} kind_t;

  function automatic kind_t kind_of(logic [6:0] o);
    case (o)
      7'h03:   return K_LW;
      7'h23:   return K_SW;
      7'h33:   return K_R;
      7'h13:   return K_I;
      7'h63:   return K_BEQ;
      7'h6F:   return K_JAL;
      7'h37:   return K_LUI;
      default: return K_OTHER;
    endcase
  endfunction

  function automatic int latency(kind_t k);
    case (k)
      K_LW:               return 5;
      K_SW, K_R, K_I, K_JAL: return 4;
      K_BEQ, K_LUI:       return 3;
      default:            return 2;
    endcase
  endfunction

  function automatic logic [2:0] exp_imm(kind_t k);
    case (k)
      K_SW:    return 3'd1;
      K_BEQ:   return 3'd2;
      K_JAL:   return 3'd3;
      K_LUI:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] exp_func(logic [2:0] f3, logic f7, logic op5);
    case (f3)
      3'b000:  return (f7 && op5) ? 3'd1 : 3'd0;
      3'b010:  return 3'd5;
      3'b110:  return 3'd3;
      3'b111:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Runs one whole instruction from its FETCH cycle; returns at the start of the next FETCH.
  task automatic exec_instr(input logic [31:0] instr, input int zmode, input string tag);
    kind_t      k;
    int         n;
    logic       e_pcw, e_adr, e_mw, e_ir, e_rw;
    logic [1:0] e_res, e_a, e_b;
    logic [2:0] e_alu;
    logic [17:0] got, exp;
    op = instr[6:0];
    funct3 = instr[14:12];
    funct7b5 = instr[30];
    k = kind_of(op);
    n = latency(k);
    for (int c = 0; c < n; c++) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      e_pcw = (c == 0) || (k == K_JAL && c == 2) || (k == K_BEQ && c == 2 && zero);
      e_adr = (k == K_LW || k == K_SW) && c == 3;
      e_mw  = (k == K_SW) && c == 3;
      e_ir  = (c == 0);
      e_rw  = (c == n - 1) && (k inside {K_LW, K_R, K_I, K_JAL, K_LUI});
      e_res = (c == 0) ? 2'd2 : (k == K_LW && c == 4) ? 2'd1 : (k == K_LUI && c == 2) ? 2'd3 : 2'd0;
      e_a = 2'd0;
      e_b = 2'd0;
      if (c == 0) e_b = 2'd2;
      else if (c == 1) begin e_a = 2'd1; e_b = 2'd1; end
      else if (c == 2) begin
        case (k)
          K_LW, K_SW, K_I: begin e_a = 2'd2; e_b = 2'd1; end
          K_R, K_BEQ:      begin e_a = 2'd2; e_b = 2'd0; end
          K_JAL:           begin e_a = 2'd1; e_b = 2'd2; end
          default:         begin e_a = 2'd0; e_b = 2'd0; end
        endcase
      end
      e_alu = (c == 2 && (k == K_R || k == K_I)) ? exp_func(funct3, funct7b5, op[5]) :
              (c == 2 && k == K_BEQ) ? 3'd1 : 3'd0;
      exp = {e_pcw, e_adr, e_mw, e_ir, e_rw, e_res, e_a, e_b, e_alu, exp_imm(k), 1'b0};
      @(negedge clk);
      got = {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca, alusrcb,
             alucontrol, immsrc, illegal};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s instr=%h cycle %0d {pcw,adr,mw,ir,rw,res,srca,srcb,alu,imm,ill} got %b want %b",
                 tag, instr, c, got, exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op = 7'h00; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({pcwrite, memwrite, irwrite, regwrite, illegal} !== 5'b0) begin
        errors++;
        $display("FAIL reset_hold enables got %b want 00000", {pcwrite, memwrite, irwrite, regwrite, illegal});
      end
      @(posedge clk);
    end
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({irwrite, pcwrite, memwrite, regwrite} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_release {ir,pcw,mw,rw} got %b want 1100", {irwrite, pcwrite, memwrite, regwrite});
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_directed();
    exec_instr(32'hFFC4A303, 2, "lw");
    exec_instr(32'h0064A423, 2, "sw");
    exec_instr(32'h00420463, 1, "beq_taken");
    exec_instr(32'h00420463, 0, "beq_not_taken");
    exec_instr(32'h40520233, 2, "sub");
    exec_instr(32'h000003B7, 2, "lui");
    exec_instr(32'h008000EF, 2, "jal");
  endtask

  task automatic test_reset_mid();
    op = 7'h23; funct3 = 3'b010; funct7b5 = 1'b0;
    repeat (3) begin
      zero = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({memwrite, regwrite, pcwrite, irwrite} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_memwrite {mw,rw,pcw,ir} got %b want 0000", {memwrite, regwrite, pcwrite, irwrite});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    exec_instr(32'h0064A423, 2, "sw_after_abort");
  endtask

  task automatic test_random();
    logic [6:0]  o;
    logic [31:0] r;
    int          sel;
    for (int i = 0; i < 60; i++) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      sel = $urandom_range(0, 6);
`else
      sel = $urandom_range(0, 7);
`endif
      case (sel)
        0: o = 7'h03;
        1: o = 7'h23;
        2: o = 7'h33;
        3: o = 7'h13;
        4: o = 7'h63;
        5: o = 7'h6F;
        6: o = 7'h37;
        default: begin
          o = 7'($urandom_range(0, 127));
          while (kind_of(o) != K_OTHER) o = 7'($urandom_range(0, 127));
        end
      endcase
      r = $urandom;
      r[6:0] = o;
      exec_instr(r, 2, "random");
    end
  endtask

  task automatic test_illegal();
`ifdef CTRL_ILLEGAL_TRAP_EN
    op = 7'h00; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    for (int c = 0; c < 5; c++) begin
      op = 7'($urandom_range(0, 127));
      @(negedge clk);
      checks++;
      if ({illegal, pcwrite, memwrite, irwrite, regwrite} !== 5'b10000) begin
        errors++;
        $display("FAIL illegal_hold cycle %0d {ill,pcw,mw,ir,rw} got %b want 10000",
                 c, {illegal, pcwrite, memwrite, irwrite, regwrite});
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({illegal, irwrite} !== 2'b01) begin
      errors++;
      $display("FAIL illegal_cleared {ill,ir} got %b want 01", {illegal, irwrite});
    end
`else
    exec_instr(32'h00000000, 2, "unknown_op_nop");
    exec_instr(32'h00000013, 2, "addi_after_nop");
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
